riscv_fetch_queue: RTL

Parametrised instruction fetch queue between `riscv_ifu` and `riscv_idu` in `riscv_top`. It replaces the direct single-entry `ifu_vld`/`ifu_addr`/`ifu_data` hand-off with a DEPTH-entry FIFO that has valid/ready backpressure on both sides. A pipeline flush on branch redirect discards every buffered instruction. This decouples AXI fetch latency from decode stalls.

---
 rtl/riscv_fetch_queue_pkg.sv | 19 +
 rtl/riscv_fetch_queue.sv | 92 +++++++++
 2 files changed

// File: rtl/riscv_fetch_queue_pkg.sv
// ----------------------------------------------------------------------------
// riscv_fetch_queue_pkg
// Shared types and defaults for the instruction fetch queue that sits between
// the fetch unit and the decoder.
//   FETCH_Q_DEPTH : default number of queue entries used by the core top level
//   FETCH_XLEN    : address / instruction width of the core
//   fetch_entry_t : one buffered fetch (PC + raw instruction word)
// ----------------------------------------------------------------------------
package riscv_fetch_queue_pkg;

    localparam int FETCH_Q_DEPTH = 4;
    localparam int FETCH_XLEN    = 32;

    typedef struct packed {
        logic [FETCH_XLEN-1:0] addr;
        logic [FETCH_XLEN-1:0] data;
    } fetch_entry_t;

endpackage

// File: rtl/riscv_fetch_queue.sv
// ----------------------------------------------------------------------------
// riscv_fetch_queue
// DEPTH-entry FIFO of fetched instructions with valid/ready on both sides and
// a flush that discards everything buffered (branch redirect).
// Ports:
//   clock, reset          : rising-edge clock, synchronous active-high reset
//   flush                 : drop all entries; suppresses both handshakes
//   ifu_vld/ifu_rdy       : enqueue handshake, ifu_addr/ifu_data payload
//   deq_vld/deq_rdy       : dequeue handshake, deq_addr/deq_data head entry
//   count, full, empty    : occupancy status from registered pointers
// ----------------------------------------------------------------------------
module riscv_fetch_queue
    import riscv_fetch_queue_pkg::*;
#(
    parameter int DEPTH = FETCH_Q_DEPTH,
    parameter int XLEN  = FETCH_XLEN,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             flush,
    input  logic             ifu_vld,
    output logic             ifu_rdy,
    input  logic [XLEN-1:0]  ifu_addr,
    input  logic [XLEN-1:0]  ifu_data,
    output logic             deq_vld,
    input  logic             deq_rdy,
    output logic [XLEN-1:0]  deq_addr,
    output logic [XLEN-1:0]  deq_data,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [AW:0] wp_q, wp_d;
    logic [AW:0] rp_q, rp_d;

    logic [DEPTH-1:0][XLEN-1:0] addr_q;
    logic [DEPTH-1:0][XLEN-1:0] data_q;

    logic enq, deq;

    assign empty = (wp_q == rp_q);
    assign full  = (wp_q[AW-1:0] == rp_q[AW-1:0]) && (wp_q[AW] != rp_q[AW]);
    assign count = CNT_W'(wp_q - rp_q);

    // Write side looks only at registered fullness: a full queue cannot take
    // a new entry even when the head leaves in the same cycle, which keeps
    // deq_rdy out of the ifu_rdy path.
    assign ifu_rdy  = !full && !flush;
    assign deq_vld  = !empty && !flush;
    assign deq_addr = addr_q[rp_q[AW-1:0]];
    assign deq_data = data_q[rp_q[AW-1:0]];

    assign enq = ifu_vld && ifu_rdy;
    assign deq = deq_vld && deq_rdy;

    always_comb begin
        wp_d = wp_q;
        rp_d = rp_q;
        if (flush) begin
            // Collapse onto the read pointer; storage is left as is.
            wp_d = rp_q;
        end else begin
            if (enq) wp_d = wp_q + PTR_ONE;
            if (deq) rp_d = rp_q + PTR_ONE;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wp_q <= '0;
            rp_q <= '0;
        end else begin
            wp_q <= wp_d;
            rp_q <= rp_d;
        end
    end

    // Storage has no reset; only the pointers define what is valid.
    always_ff @(posedge clock) begin
        if (enq) begin
            addr_q[wp_q[AW-1:0]] <= ifu_addr;
            data_q[wp_q[AW-1:0]] <= ifu_data;
        end
    end

endmodule
